pc_fetch_stage: RTL and testbench
=================================

// Module: pc_fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of the byte-addressed instruction ROM.
//  - Owns the program counter and drives the ROM address.
//  - Captures the returned 32-bit word together with its PC into an IF/ID register.
//  - Handles stall, branch/jump redirect (with flush), and halts cleanly at the end of ROM.
//  - Keeps a count of delivered instructions.
// PARAMETERS
//  ADDRESS_WIDTH  32            PC / ROM address width in bits
//  INSTR_WIDTH    32            fetched instruction width in bits
//  ROM_BYTES      28            ROM size in bytes; last legal fetch PC = ROM_BYTES-4
//  RESET_PC       0             PC value loaded on reset
//  NOP_INSTR      32'h00000013  bubble word (addi x0,x0,0) placed in IF/ID when invalid
// PORTS
//  clk_i           input   1              rising-edge clock
//  rst_i           input   1              synchronous, active-high reset
//  pc_o            output  ADDRESS_WIDTH  current PC; wired to ROM a_i
//  instr_i         input   INSTR_WIDTH    ROM rd_o (combinational read of pc_o)
//  stall_i         input   1              hold PC and IF/ID (hazard unit)
//  redirect_i      input   1              taken branch/jump: load target, flush IF/ID
//  target_i        input   ADDRESS_WIDTH  redirect target byte address
//  if_id_instr_o   output  INSTR_WIDTH    registered instruction to decode
//  if_id_pc_o      output  ADDRESS_WIDTH  PC of if_id_instr_o
//  if_id_valid_o   output  1              1 = IF/ID holds a real instruction
//  halted_o        output  1              1 = PC ran past ROM end; fetch stopped
//  fetch_count_o   output  32             instructions delivered since reset, saturating
// BEHAVIOUR
//  Reset values (rst_i high at a clock edge; overrides every other input)
//   - pc_q = RESET_PC; state = START.
//   - if_id_instr_o = NOP_INSTR; if_id_pc_o = 0; if_id_valid_o = 0.
//   - halted_o = 0; fetch_count_o = 0.
//  ROM interface
//   - pc_o = pc_q, driven from a register.
//   - instr_i is consumed in the same cycle; ROM read latency is zero.
//  FSM states: START, RUN, HALT. Priority each edge: rst_i > redirect_i > stall_i > state action.
//  START
//   - Single bubble cycle after reset: IF/ID invalid, PC held.
//   - Always goes to RUN, unless redirect_i is high.
//  RUN
//   - If pc_q > ROM_BYTES-4: go to HALT; PC held; IF/ID bubble.
//   - Else: IF/ID <= {instr_i, pc_q, valid=1}; pc_q <= pc_q+4 (mod 2^ADDRESS_WIDTH); fetch_count +1.
//  HALT
//   - halted_o = 1; IF/ID bubble every cycle; PC held.
//   - Exits only on redirect_i or rst_i.
//  redirect_i (in any state)
//   - pc_q <= {target_i[AW-1:2], 2'b00}; bits [1:0] of target_i are ignored.
//   - IF/ID <= bubble; the word fetched this cycle is on the wrong path and is dropped.
//   - state <= RUN; halted_o <= 0.
//   - Takes effect even when stall_i is high in the same cycle.
//  stall_i (without redirect)
//   - pc_q, all IF/ID outputs, state and fetch_count hold their values.
//   - In START, stall delays the move to RUN.
//  Bubble: if_id_instr_o = NOP_INSTR, if_id_valid_o = 0, if_id_pc_o = pc_q.
//  fetch_count_o increments only on a valid capture and holds at 32'hFFFFFFFF.
//  PC wrap: pc_q+4 overflow wraps to 0 (reachable only when ROM_BYTES is near 2^AW).
// TESTING
//  1 Reset, ROM words W0,W1,W2 at 0,4,8 -> cycle1 valid=0; then if_id_pc_o=0,4,8 with W0,W1,W2; count=3.
//  2 stall_i high 2 cycles while pc_o=8 -> pc_o, if_id_* and count unchanged; pc 8 delivered after release.
//  3 redirect_i, target_i=0x06, at pc_o=12 -> next pc_o=4, valid=0; following cycle if_id_pc_o=4, valid=1.
//  4 Default ROM_BYTES=28, free run -> last valid if_id_pc_o=24; then halted_o=1, pc_o=28 held, valid=0; redirect to 0 resumes.
//  5 stall_i and redirect_i high together, target 0x10 -> pc_o=0x10, IF/ID bubble (redirect wins).
//  6 rst_i pulsed mid-run with count=5 -> next edge: pc_o=0, valid=0, count=0, halted_o=0; START bubble then RUN.

Source files
------------

// File: rtl/pc_fetch_stage_if.sv
// Bundle of signals between the fetch stage and its surroundings.
// Covers the ROM port, the hazard and redirect controls, and the IF/ID outputs.
// The master side is the fetch stage. The slave side is the ROM/decode environment.
interface pc_fetch_stage_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32
) ();

  logic [ADDRESS_WIDTH-1:0] pc_o;
  logic [INSTR_WIDTH-1:0]   instr_i;
  logic                     stall_i;
  logic                     redirect_i;
  logic [ADDRESS_WIDTH-1:0] target_i;
  logic [INSTR_WIDTH-1:0]   if_id_instr_o;
  logic [ADDRESS_WIDTH-1:0] if_id_pc_o;
  logic                     if_id_valid_o;
  logic                     halted_o;
  logic [31:0]              fetch_count_o;

  modport master (
    output pc_o, if_id_instr_o, if_id_pc_o, if_id_valid_o, halted_o, fetch_count_o,
    input  instr_i, stall_i, redirect_i, target_i
  );

  modport slave (
    input  pc_o, if_id_instr_o, if_id_pc_o, if_id_valid_o, halted_o, fetch_count_o,
    output instr_i, stall_i, redirect_i, target_i
  );

endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage. It owns the PC and drives the ROM address.
// Each cycle it registers the returned word and its PC into IF/ID.
// It handles stall, redirect with flush, and halting past the end of ROM.
// It also counts delivered instructions, saturating at all-ones.
module pc_fetch_stage #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       INSTR_WIDTH   = 32,
  parameter int                       ROM_BYTES     = 28,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR     = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pc_fetch_stage_if.master  bus
);

  typedef enum logic [1:0] {ST_START, ST_RUN, ST_HALT} state_e;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_PC   = ADDRESS_WIDTH'(ROM_BYTES - 4);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MSK = ~ADDRESS_WIDTH'(3);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] if_pc_q, if_pc_d;
  logic                     valid_q, valid_d;
  logic [31:0]              count_q, count_d;

  // Register the FSM state and the datapath. Reset overrides every other input.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_START;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      if_pc_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Compute next state and next IF/ID contents. Priority is redirect, then stall, then the state action.
  always_comb begin
    // NOTE: every output gets a hold value first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if_pc_d = if_pc_q;
    valid_d = valid_q;
    count_d = count_q;

    if (bus.redirect_i) begin
      // The word fetched this cycle is on the wrong path, so drop it.
      pc_d    = bus.target_i & ALIGN_MSK;
      instr_d = NOP_INSTR;
      if_pc_d = pc_q;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (!bus.stall_i) begin
      unique case (state_q)
        ST_START: begin
          instr_d = NOP_INSTR;
          if_pc_d = pc_q;
          valid_d = 1'b0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pc_q > LAST_PC) begin
            instr_d = NOP_INSTR;
            if_pc_d = pc_q;
            valid_d = 1'b0;
            state_d = ST_HALT;
          end else begin
            instr_d = bus.instr_i;
            if_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDRESS_WIDTH'(4);
            if (count_q != '1) count_d = count_q + 32'd1;
          end
        end
        ST_HALT: begin
          instr_d = NOP_INSTR;
          if_pc_d = pc_q;
          valid_d = 1'b0;
        end
        default: state_d = ST_START;
      endcase
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.if_id_instr_o = instr_q;
  assign bus.if_id_pc_o    = if_pc_q;
  assign bus.if_id_valid_o = valid_q;
  assign bus.halted_o      = (state_q == ST_HALT);
  assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Testbench for pc_fetch_stage. It runs directed scenarios followed by random stall, redirect
// and reset traffic. All checks compare against a behavioural model of the fetch rules.
module tb_pc_fetch_stage;

  localparam int          AW        = 32;
  localparam int          IW        = 32;
  localparam int          ROM_BYTES = 28;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic clk;
  logic rst;

  pc_fetch_stage_if #(.ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  pc_fetch_stage #(
    .ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW), .ROM_BYTES(ROM_BYTES),
    .RESET_PC('0), .NOP_INSTR(NOP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents. Addresses outside the ROM return a recognisable filler word.
  logic [31:0] rom_mem [0:ROM_BYTES/4-1];

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr < ROM_BYTES) return rom_mem[addr / 4];
    return 32'hBAD0_0000 ^ addr;
  endfunction

  assign bus.instr_i = rom_word(bus.pc_o);

  // Behavioural model. Phase: 0 = waiting for first fetch, 1 = fetching, 2 = stopped past ROM end.
  int          m_phase;
  logic [31:0] m_pc, m_ins, m_ipc, m_cnt;
  logic        m_val;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_ins = NOP;
    m_ipc = m_pc;
    m_val = 1'b0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] t);
    if (r) begin
      m_phase = 0; m_pc = 0; m_ins = NOP; m_ipc = 0; m_val = 0; m_cnt = 0;
    end else if (rd) begin
      model_bubble();
      m_pc    = t - (t % 4);
      m_phase = 1;
    end else if (s) begin
      // everything holds
    end else if (m_phase == 0) begin
      model_bubble();
      m_phase = 1;
    end else if (m_phase == 2) begin
      model_bubble();
    end else if (m_pc > ROM_BYTES - 4) begin
      model_bubble();
      m_phase = 2;
    end else begin
      m_ins = rom_word(m_pc);
      m_ipc = m_pc;
      m_val = 1'b1;
      m_pc  = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},     bus.pc_o,          m_pc);
    check({tag, ".instr"},  bus.if_id_instr_o, m_ins);
    check({tag, ".if_pc"},  bus.if_id_pc_o,    m_ipc);
    check({tag, ".valid"},  bus.if_id_valid_o, m_val);
    check({tag, ".halted"}, bus.halted_o,      (m_phase == 2));
    check({tag, ".count"},  bus.fetch_count_o, m_cnt);
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, then compare everything.
  task automatic step(input string tag, input logic r, input logic s, input logic rd,
                      input logic [31:0] t);
    @(negedge clk);
    rst = r; bus.stall_i = s; bus.redirect_i = rd; bus.target_i = t;
    model_edge(r, s, rd, t);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  logic [31:0] last_valid_pc;

  initial begin
    rst = 1'b1; bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.target_i = '0;
    for (int i = 0; i < ROM_BYTES / 4; i++) rom_mem[i] = $urandom;

    // Reset state
    step("reset0", 1, 0, 0, 0);
    step("reset1", 1, 0, 0, 0);
    check("rst.valid", bus.if_id_valid_o, 0);
    check("rst.instr", bus.if_id_instr_o, NOP);

    // Start bubble, then W0, W1, W2
    step("t1.start", 0, 0, 0, 0);
    check("t1.start_valid", bus.if_id_valid_o, 0);
    step("t1.w0", 0, 0, 0, 0);
    check("t1.w0_word", bus.if_id_instr_o, rom_mem[0]);
    step("t1.w1", 0, 0, 0, 0);
    step("t1.w2", 0, 0, 0, 0);
    check("t1.w2_pc", bus.if_id_pc_o, 8);
    check("t1.count", bus.fetch_count_o, 3);

    // Redirect at pc 12 to 0x06, so fetch lands on word 4
    step("t3.redir", 0, 0, 1, 32'h6);
    check("t3.pc", bus.pc_o, 4);
    check("t3.valid", bus.if_id_valid_o, 0);
    step("t3.next", 0, 0, 0, 0);
    check("t3.if_pc", bus.if_id_pc_o, 4);
    check("t3.valid1", bus.if_id_valid_o, 1);

    // Stall two cycles with pc at 8
    check("t2.pc_pre", bus.pc_o, 8);
    step("t2.stall0", 0, 1, 0, 0);
    step("t2.stall1", 0, 1, 0, 0);
    check("t2.pc_held", bus.pc_o, 8);
    check("t2.if_pc_held", bus.if_id_pc_o, 4);
    step("t2.release", 0, 0, 0, 0);
    check("t2.if_pc", bus.if_id_pc_o, 8);

    // Free run to the end of ROM, with a bounded loop
    last_valid_pc = '1;
    for (int i = 0; i < 20 && !bus.halted_o; i++) begin
      if (bus.if_id_valid_o) last_valid_pc = bus.if_id_pc_o;
      step("t4.run", 0, 0, 0, 0);
    end
    check("t4.halted", bus.halted_o, 1);
    check("t4.last_pc", last_valid_pc, 24);
    check("t4.pc", bus.pc_o, 28);
    step("t4.hold", 0, 0, 0, 0);
    check("t4.pc_held", bus.pc_o, 28);
    check("t4.valid", bus.if_id_valid_o, 0);
    step("t4.resume", 0, 0, 1, 0);
    check("t4.resume_halted", bus.halted_o, 0);
    step("t4.resume1", 0, 0, 0, 0);
    check("t4.resume_word", bus.if_id_instr_o, rom_mem[0]);

    // Stall and redirect together: redirect wins
    step("t5.both", 0, 1, 1, 32'h10);
    check("t5.pc", bus.pc_o, 32'h10);
    check("t5.valid", bus.if_id_valid_o, 0);

    // Mid-run reset with count at 5
    step("t6.rst_a", 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("t6.run", 0, 0, 0, 0);
    check("t6.count5", bus.fetch_count_o, 5);
    step("t6.rst", 1, 0, 0, 0);
    check("t6.pc", bus.pc_o, 0);
    check("t6.count0", bus.fetch_count_o, 0);
    step("t6.start", 0, 0, 0, 0);
    check("t6.start_valid", bus.if_id_valid_o, 0);
    step("t6.first", 0, 0, 0, 0);
    check("t6.first_valid", bus.if_id_valid_o, 1);

    // Random traffic, including unaligned and out-of-range targets
    for (int i = 0; i < 400; i++) begin
      logic        r, s, rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 25);
      rd = ($urandom_range(0, 99) < 10);
      t  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 40));
      step("rand", r, s, rd, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
